// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/result bundle between the operation decoder and the divider
interface div_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             START;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             BUSY;
  logic             DONE;
  logic             DIV0;
  logic [WIDTH-1:0] QUOT;
  logic [WIDTH-1:0] REM;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, DIV0, QUOT, REM
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, DIV0, QUOT, REM
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - sequential restoring divider with start/done handshake
module div_sequencer #(
  parameter int WIDTH = 4
) (
  input logic           CLK,
  input logic           RST,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TEST  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic             div0_flag;
  logic [WIDTH:0]   diff;

  // Trial subtraction of the divisor from the partial remainder
  assign diff = a - {1'b0, m};

  // BUSY comes straight from the state register, so START has no path to it
  assign bus.BUSY = (state != IDLE);

  // Division sequencer: accept, shift/test loop, then publish results for one DONE cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      div0_flag <= 1'b0;
      bus.QUOT  <= '0;
      bus.REM   <= '0;
      bus.DIV0  <= 1'b0;
      bus.DONE  <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            if (bus.DIVISOR != '0) begin
              q     <= bus.DIVIDEND;
              m     <= bus.DIVISOR;
              a     <= '0;
              cnt   <= CW'(WIDTH);
              state <= SHIFT;
            end else begin
              // Divide by zero skips the loop: quotient saturates, remainder is the dividend
              q         <= '1;
              a         <= {1'b0, bus.DIVIDEND};
              div0_flag <= 1'b1;
              state     <= FIN;
            end
          end
        end
        SHIFT: begin
          {a, q} <= {a[WIDTH-1:0], q, 1'b0};
          state  <= TEST;
        end
        TEST: begin
          if (a >= {1'b0, m}) begin
            a    <= diff;
            q[0] <= 1'b1;
          end
          cnt   <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? FIN : SHIFT;
        end
        FIN: begin
          bus.QUOT  <= q;
          bus.REM   <= a[WIDTH-1:0];
          bus.DIV0  <= div0_flag;
          bus.DONE  <= 1'b1;
          div0_flag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;
  localparam int W = 4;
  localparam int LAT = 2 * W + 1;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  div_sequencer_if #(.WIDTH(W)) bus_if ();

  div_sequencer #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(bus_if.BUSY), 0);
    check({tag, "_done"}, 32'(bus_if.DONE), 0);
    check({tag, "_div0"}, 32'(bus_if.DIV0), 0);
    check({tag, "_quot"}, 32'(bus_if.QUOT), 0);
    check({tag, "_rem"},  32'(bus_if.REM),  0);
  endtask

  // One division from IDLE; optionally pokes a competing START at lat == poke_at
  task automatic run_op(input int dd, input int dv, input int poke_at);
    int lat;
    int busy_cnt;
    int exp_q;
    int exp_r;
    int exp_z;
    int exp_lat;
    lat = 0;
    busy_cnt = 0;
    if (dv == 0) begin
      exp_q = (1 << W) - 1;
      exp_r = dd;
      exp_z = 1;
      exp_lat = 1;
    end else begin
      exp_q = dd / dv;
      exp_r = dd % dv;
      exp_z = 0;
      exp_lat = LAT;
    end
    bus_if.START    = 1'b1;
    bus_if.DIVIDEND = W'(dd);
    bus_if.DIVISOR  = W'(dv);
    tick();
    bus_if.START    = 1'b0;
    bus_if.DIVIDEND = W'($urandom_range(0, 15));
    bus_if.DIVISOR  = W'($urandom_range(0, 15));
    while (!bus_if.DONE && lat < 40) begin
      if (bus_if.BUSY) busy_cnt++;
      if (lat == poke_at) begin
        bus_if.START    = 1'b1;
        bus_if.DIVIDEND = W'(8);
        bus_if.DIVISOR  = W'(2);
      end else begin
        bus_if.START = 1'b0;
      end
      tick();
      lat++;
    end
    bus_if.START = 1'b0;
    check($sformatf("lat_%0d_%0d", dd, dv), lat, exp_lat);
    check($sformatf("busy_cycles_%0d_%0d", dd, dv), busy_cnt, exp_lat);
    check($sformatf("done_%0d_%0d", dd, dv), 32'(bus_if.DONE), 1);
    check($sformatf("busy_at_done_%0d_%0d", dd, dv), 32'(bus_if.BUSY), 0);
    check($sformatf("quot_%0d_%0d", dd, dv), 32'(bus_if.QUOT), exp_q);
    check($sformatf("rem_%0d_%0d", dd, dv), 32'(bus_if.REM), exp_r);
    check($sformatf("div0_%0d_%0d", dd, dv), 32'(bus_if.DIV0), exp_z);
    tick();
    check($sformatf("done_pulse_%0d_%0d", dd, dv), 32'(bus_if.DONE), 0);
    check($sformatf("quot_hold_%0d_%0d", dd, dv), 32'(bus_if.QUOT), exp_q);
  endtask

  initial begin
    int done_cnt;
    int idle_cnt;
    int last_done;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus_if.START    = 1'b0;
    bus_if.DIVIDEND = '0;
    bus_if.DIVISOR  = '0;
    tick();
    tick();
    RST = 1'b0;
    check_idle_zero("reset");
    tick();

    // Directed cases from the plan
    run_op(13, 4, -1);
    run_op(15, 1, -1);
    run_op(5, 7, -1);
    run_op(0, 3, -1);
    run_op(9, 0, -1);
    run_op(6, 2, -1);

    // START while busy is ignored, and no second DONE follows
    run_op(14, 3, 3);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.DONE) done_cnt++;
      tick();
    end
    check("ignored_start_extra_done", done_cnt, 0);
    check("ignored_start_busy", 32'(bus_if.BUSY), 0);

    // Reset mid-flight abandons the operation
    run_op(6, 2, -1);
    bus_if.START    = 1'b1;
    bus_if.DIVIDEND = W'(11);
    bus_if.DIVISOR  = W'(2);
    tick();
    bus_if.START = 1'b0;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_idle_zero("midreset");
    done_cnt = 0;
    idle_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.DONE) done_cnt++;
      if (bus_if.BUSY) idle_cnt++;
      tick();
    end
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_busy", idle_cnt, 0);
    run_op(11, 2, -1);

    // START held high: back-to-back operations
    bus_if.START    = 1'b1;
    bus_if.DIVIDEND = W'(10);
    bus_if.DIVISOR  = W'(3);
    tick();
    done_cnt = 0;
    idle_cnt = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (!bus_if.BUSY) idle_cnt++;
      if (bus_if.DONE) begin
        done_cnt++;
        check("b2b_quot", 32'(bus_if.QUOT), 3);
        check("b2b_rem", 32'(bus_if.REM), 1);
        if (last_done < 0) check("b2b_first_lat", cyc, LAT);
        else check("b2b_interval", cyc - last_done, LAT + 1);
        last_done = cyc;
      end
      tick();
    end
    check("b2b_done_count", done_cnt, 4);
    check("b2b_idle_cycles", idle_cnt, done_cnt);
    bus_if.START = 1'b0;
    for (int i = 0; i < 20 && bus_if.BUSY; i++) tick();
    check("b2b_drain_busy", 32'(bus_if.BUSY), 0);
    tick();

    // Random operands, including zero divisors
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
